// File: rtl/imm_ext_pkg.sv
// Shared opcode constants, decode kinds and buffer states for the ID-stage immediate sequencer.
package imm_ext_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned PFX_W    = 3;

  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'b001111;

  localparam logic [PFX_W-1:0] OP_LOAD_PFX  = 3'b100;
  localparam logic [PFX_W-1:0] OP_STORE_PFX = 3'b101;

  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_ILL} ext_kind_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} fifo_state_t;

  // Loads and stores are matched by their 3-bit major-opcode prefix.
  function automatic ext_kind_t decode_kind(input logic [OPCODE_W-1:0] op);
    ext_kind_t k;
    k = EXT_ILL;
    case (op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_BEQ, OP_BNE: k = EXT_SIGN;
      OP_ANDI, OP_ORI, OP_XORI:                              k = EXT_ZERO;
      OP_LUI:                                                k = EXT_LUI;
      default: begin
        if ((op[OPCODE_W-1 -: PFX_W] == OP_LOAD_PFX) ||
            (op[OPCODE_W-1 -: PFX_W] == OP_STORE_PFX)) begin
          k = EXT_SIGN;
        end
      end
    endcase
    return k;
  endfunction

  function automatic logic is_branch(input logic [OPCODE_W-1:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/imm_ext_ctrl_extend.sv
// Zero/sign extension of an immediate field to the datapath width.
module extend
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_ORIGINAL_SIZE = 16,
  parameter int unsigned DATA_EXTENDED_SIZE = 32
) (
  input  logic [DATA_ORIGINAL_SIZE-1:0] i_data,
  input  logic                          i_is_signed,
  output logic [DATA_EXTENDED_SIZE-1:0] o_data_c
);

  localparam int unsigned PadW = DATA_EXTENDED_SIZE - DATA_ORIGINAL_SIZE;

  logic pad_bit;

  assign pad_bit  = i_is_signed & i_data[DATA_ORIGINAL_SIZE-1];
  assign o_data_c = {{PadW{pad_bit}}, i_data};

endmodule

// File: rtl/imm_ext_ctrl.sv
// ID-stage immediate sequencer: opcode decode, shared extender, 2-entry skid buffer toward ID/EX.
// Optional IMM_EXT_BRANCH_SHIFT_EN: BEQ/BNE immediates become byte offsets (sign-extended imm << 2).
module imm_ext_ctrl
  import imm_ext_pkg::*;
#(
  parameter int unsigned DATA_ORIGINAL_SIZE = 16,
  parameter int unsigned DATA_EXTENDED_SIZE = 32,
  parameter int unsigned OPCODE_SIZE        = 6
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [OPCODE_SIZE-1:0]        i_opcode,
  input  logic [DATA_ORIGINAL_SIZE-1:0] i_imm,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_EXTENDED_SIZE-1:0] o_imm,
  output logic                          o_is_signed,
  output logic                          o_illegal
);

  localparam int unsigned PadW = DATA_EXTENDED_SIZE - DATA_ORIGINAL_SIZE;

  ext_kind_t                     kind_c;
  logic                          ext_signed_c;
  logic [DATA_EXTENDED_SIZE-1:0] ext_c;
  logic [DATA_EXTENDED_SIZE-1:0] dec_imm_c;
  logic                          dec_illegal_c;
`ifdef IMM_EXT_BRANCH_SHIFT_EN
  logic                          branch_c;
`endif

  fifo_state_t                   state_q, state_d;
  logic                          ready_q, ready_d;
  logic                          valid_q, valid_d;
  logic [DATA_EXTENDED_SIZE-1:0] head_imm_q, head_imm_d;
  logic                          head_signed_q, head_signed_d;
  logic                          head_illegal_q, head_illegal_d;
  logic [DATA_EXTENDED_SIZE-1:0] skid_imm_q, skid_imm_d;
  logic                          skid_signed_q, skid_signed_d;
  logic                          skid_illegal_q, skid_illegal_d;
  logic                          push_c, pop_c;

  assign kind_c        = decode_kind(OPCODE_W'(i_opcode));
  assign ext_signed_c  = (kind_c == EXT_SIGN);
  assign dec_illegal_c = (kind_c == EXT_ILL);
`ifdef IMM_EXT_BRANCH_SHIFT_EN
  assign branch_c      = is_branch(OPCODE_W'(i_opcode));
`endif

  extend #(
    .DATA_ORIGINAL_SIZE(DATA_ORIGINAL_SIZE),
    .DATA_EXTENDED_SIZE(DATA_EXTENDED_SIZE)
  ) u_extend (
    .i_data     (i_imm),
    .i_is_signed(ext_signed_c),
    .o_data_c   (ext_c)
  );

  // Result mux: extender output, LUI placement, or zero for illegal opcodes.
  always_comb begin
    dec_imm_c = '0;
    case (kind_c)
      EXT_ZERO, EXT_SIGN: dec_imm_c = ext_c;
      EXT_LUI:            dec_imm_c = {i_imm, {PadW{1'b0}}};
      default:            dec_imm_c = '0;
    endcase
`ifdef IMM_EXT_BRANCH_SHIFT_EN
    // Shift happens in the full datapath width, so bits above it simply fall off.
    if (branch_c) begin
      dec_imm_c = ext_c << 2;
    end
`endif
  end

  assign push_c = i_valid & ready_q;
  assign pop_c  = valid_q & i_ready;

  // Next-state and buffer update; head always holds the oldest entry.
  always_comb begin
    state_d        = state_q;
    head_imm_d     = head_imm_q;
    head_signed_d  = head_signed_q;
    head_illegal_d = head_illegal_q;
    skid_imm_d     = skid_imm_q;
    skid_signed_d  = skid_signed_q;
    skid_illegal_d = skid_illegal_q;

    case (state_q)
      ST_EMPTY: begin
        if (push_c) begin
          head_imm_d     = dec_imm_c;
          head_signed_d  = ext_signed_c;
          head_illegal_d = dec_illegal_c;
          state_d        = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push_c && !pop_c) begin
          skid_imm_d     = dec_imm_c;
          skid_signed_d  = ext_signed_c;
          skid_illegal_d = dec_illegal_c;
          state_d        = ST_FULL;
        end else if (pop_c && !push_c) begin
          state_d = ST_EMPTY;
        end else if (push_c && pop_c) begin
          head_imm_d     = dec_imm_c;
          head_signed_d  = ext_signed_c;
          head_illegal_d = dec_illegal_c;
        end
      end
      ST_FULL: begin
        if (pop_c) begin
          head_imm_d     = skid_imm_q;
          head_signed_d  = skid_signed_q;
          head_illegal_d = skid_illegal_q;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (i_flush) begin
      state_d = ST_EMPTY;
    end

    ready_d = (state_d != ST_FULL);
    valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q        <= ST_EMPTY;
      ready_q        <= 1'b1;
      valid_q        <= 1'b0;
      head_imm_q     <= '0;
      head_signed_q  <= 1'b0;
      head_illegal_q <= 1'b0;
      skid_imm_q     <= '0;
      skid_signed_q  <= 1'b0;
      skid_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      valid_q        <= valid_d;
      head_imm_q     <= head_imm_d;
      head_signed_q  <= head_signed_d;
      head_illegal_q <= head_illegal_d;
      skid_imm_q     <= skid_imm_d;
      skid_signed_q  <= skid_signed_d;
      skid_illegal_q <= skid_illegal_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_imm       = head_imm_q;
  assign o_is_signed = head_signed_q;
  assign o_illegal   = head_illegal_q;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Scoreboard bench for imm_ext_ctrl: directed vectors, expected results queued on upstream accept.
module tb_imm_ext_ctrl;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [5:0]  i_opcode;
  logic [15:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_imm;
  logic        o_is_signed;
  logic        o_illegal;

  typedef struct packed {
    logic [31:0] imm;
    logic        s;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  int   vectors;
  int   miscompares;

  imm_ext_ctrl dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_opcode   (i_opcode),
    .i_imm      (i_imm),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_imm      (o_imm),
    .o_is_signed(o_is_signed),
    .o_illegal  (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every downstream transfer must match the oldest queued expectation.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset_n && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %h, expected no output", o_imm);
      end else begin
        e = exp_q.pop_front();
        chk("out_imm", o_imm, e.imm);
        chk("out_signed", 32'(o_is_signed), 32'(e.s));
        chk("out_illegal", 32'(o_illegal), 32'(e.ill));
      end
    end
  end

  // Logger: queue the expectation when the upstream transfer will occur at the next edge.
  always @(negedge i_clk) begin
    #1;
    if (!i_reset_n || i_flush) exp_q.delete();
    else if (i_valid && o_ready) exp_q.push_back(exp_cur);
  end

  task automatic present(input logic [5:0] op, input logic [15:0] imm,
                         input logic [31:0] eimm, input logic es, input logic eill);
    @(posedge i_clk);
    #1;
    i_valid  = 1'b1;
    i_opcode = op;
    i_imm    = imm;
    exp_cur  = '{imm: eimm, s: es, ill: eill};
  endtask

  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge i_clk);
      #2;
      if (o_ready) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: got o_ready=0, expected 1 within 50 cycles");
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [15:0] imm,
                      input logic [31:0] eimm, input logic es, input logic eill);
    present(op, imm, eimm, es, eill);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_flush = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] beq_exp;
    logic [31:0] bne_exp;
    int          budget;
`ifdef IMM_EXT_BRANCH_SHIFT_EN
    beq_exp = 32'hFFFF_FFFC;
    bne_exp = 32'h0000_000C;
`else
    beq_exp = 32'hFFFF_FFFF;
    bne_exp = 32'h0000_0003;
`endif
    vectors = 0; miscompares = 0;
    i_clk = 1'b0; i_reset_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_ready = 1'b1; i_opcode = '0; i_imm = '0; exp_cur = '0;

    #12;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_imm", o_imm, 32'h0);
    chk("rst_signed", 32'(o_is_signed), 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    #10 i_reset_n = 1'b1;

    // Single ADDI: one-cycle latency.
    send(6'b001000, 16'hFFF0, 32'hFFFF_FFF0, 1'b1, 1'b0);
    idle(1);
    @(negedge i_clk); #2;
    chk("lat_valid", 32'(o_valid), 32'd1);
    chk("lat_imm", o_imm, 32'hFFFF_FFF0);
    idle(2);

    // Back-to-back burst across all decode classes.
    send(6'b001101, 16'h8001, 32'h0000_8001, 1'b0, 1'b0);
    send(6'b001111, 16'h1234, 32'h1234_0000, 1'b0, 1'b0);
    send(6'b001110, 16'hFFFF, 32'h0000_FFFF, 1'b0, 1'b0);
    send(6'b001100, 16'h8000, 32'h0000_8000, 1'b0, 1'b0);
    send(6'b100011, 16'h8000, 32'hFFFF_8000, 1'b1, 1'b0);
    send(6'b101011, 16'h0004, 32'h0000_0004, 1'b1, 1'b0);
    send(6'b001001, 16'h7FFF, 32'h0000_7FFF, 1'b1, 1'b0);
    send(6'b001010, 16'h8000, 32'hFFFF_8000, 1'b1, 1'b0);
    send(6'b001011, 16'hFFFE, 32'hFFFF_FFFE, 1'b1, 1'b0);
    send(6'b000101, 16'h0003, bne_exp, 1'b1, 1'b0);
    send(6'b000100, 16'hFFFF, beq_exp, 1'b1, 1'b0);
    send(6'b010000, 16'hABCD, 32'h0, 1'b0, 1'b1);
    idle(3);

    // Stall: two entries fill the buffer, third is held off.
    i_ready = 1'b0;
    send(6'b001000, 16'h0011, 32'h0000_0011, 1'b1, 1'b0);
    send(6'b001101, 16'h0022, 32'h0000_0022, 1'b0, 1'b0);
    present(6'b001110, 16'h0033, 32'h0000_0033, 1'b0, 1'b0);
    @(negedge i_clk); #2;
    chk("full_ready", 32'(o_ready), 32'd0);
    chk("full_valid", 32'(o_valid), 32'd1);
    chk("full_hold_imm", o_imm, 32'h0000_0011);
    @(negedge i_clk); #2;
    chk("full_hold_imm2", o_imm, 32'h0000_0011);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    wait_accept();
    idle(4);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // Flush in ONE overriding a same-cycle accept.
    i_ready = 1'b0;
    send(6'b001000, 16'h0044, 32'h0000_0044, 1'b1, 1'b0);
    present(6'b001000, 16'h0055, 32'h0000_0055, 1'b1, 1'b0);
    i_flush = 1'b1;
    idle(1);
    @(negedge i_clk); #2;
    chk("flush1_valid", 32'(o_valid), 32'd0);
    chk("flush1_ready", 32'(o_ready), 32'd1);

    // Flush in FULL together with i_valid.
    send(6'b001000, 16'h0066, 32'h0000_0066, 1'b1, 1'b0);
    send(6'b001000, 16'h0077, 32'h0000_0077, 1'b1, 1'b0);
    present(6'b001000, 16'h0088, 32'h0000_0088, 1'b1, 1'b0);
    i_flush = 1'b1;
    idle(1);
    @(negedge i_clk); #2;
    chk("flush2_valid", 32'(o_valid), 32'd0);
    chk("flush2_ready", 32'(o_ready), 32'd1);
    i_ready = 1'b1;
    idle(3);
    send(6'b001101, 16'h0001, 32'h0000_0001, 1'b0, 1'b0);
    idle(3);

    // Asynchronous reset between edges with a full buffer.
    i_ready = 1'b0;
    send(6'b001000, 16'h0101, 32'h0000_0101, 1'b1, 1'b0);
    send(6'b001101, 16'h0202, 32'h0000_0202, 1'b0, 1'b0);
    idle(1);
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_imm", o_imm, 32'h0);
    chk("arst_ready", 32'(o_ready), 32'd1);
    exp_q.delete();
    #2;
    i_reset_n = 1'b1;
    i_ready = 1'b1;

    send(6'b111111, 16'h1234, 32'h0, 1'b0, 1'b1);
    send(6'b001000, 16'h0001, 32'h0000_0001, 1'b1, 1'b0);
    idle(1);

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge i_clk);
      budget++;
    end
    #1;
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
